// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and prefix constants; also used by the downstream scancode decoders.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  typedef logic [15:0] ps2_scancode_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchronizer, falling-edge detect and 11-bit frame deframer.
// Optional inter-edge timeout enabled by PS2_RX_TIMEOUT_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 16) begin : g_bad_param
    $error("ps2_frame_rx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 16");
  end

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  ps2_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       timeout;

  // Synchronizers reset to 1 so the idle-high bus never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (fall || state_q == IDLE) to_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    // A timeout takes priority over a falling edge in the same cycle.
    if (timeout) begin
      state_d  = IDLE;
      byte_err = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          if (data_s && (^{shift_q, par_q})) byte_valid = 1'b1;
          else                               byte_err   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_byte = shift_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deframes bytes and folds E0/F0 prefixes into a 16-bit make code plus break flag.
// Define PS2_RX_TIMEOUT_EN to enable the inter-edge frame timeout.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] scancode,
  output logic        scancode_valid,
  output logic        is_break,
  output logic        frame_err,
  output logic        busy
);

  logic [7:0] rx_byte;
  logic       byte_valid, byte_err;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .busy      (busy)
  );

  ps2_scancode_t code_q, code_d;
  logic          is_break_q, is_break_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;

  always_comb begin
    code_d     = code_q;
    is_break_d = is_break_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    ext_d      = ext_q;
    brk_d      = brk_q;
    // An errored frame drops any pending prefixes but leaves the last code intact.
    if (byte_err) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT_PREFIX) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BREAK_PREFIX) begin
        brk_d = 1'b1;
      end else begin
        code_d     = {(ext_q ? PS2_EXT_PREFIX : 8'h00), rx_byte};
        is_break_d = brk_q;
        valid_d    = 1'b1;
        ext_d      = 1'b0;
        brk_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q     <= '0;
      is_break_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      code_q     <= code_d;
      is_break_q <= is_break_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  assign scancode       = code_q;
  assign is_break       = is_break_q;
  assign scancode_valid = valid_q;
  assign frame_err      = err_q;

endmodule
